fifo_digital: RTL and testbench

//   Synchronous valid/ready FIFO for digital emulator signals; buffers samples ahead of a
//   mem_digital state register so producer bursts are absorbed without loss.

---
 rtl/fifo_digital_pkg.sv | 21 ++
 rtl/fifo_digital_ptr.sv | 38 +++
 rtl/fifo_digital.sv | 121 ++++++++++++
 tb/tb_fifo_digital.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_digital_pkg.sv
// Shared types and sizing helpers for the fifo_digital valid/ready FIFO.
package fifo_digital_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned clog2_occ(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer addressing 0..depth-1 (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_digital_ptr.sv
// Wrapping pointer register for fifo_digital; counts 0..depth-1 with explicit wrap,
// so any depth is supported without power-of-two masking.
module fifo_digital_ptr
    import fifo_digital_pkg::*;
#(
    parameter int unsigned depth = 4,
    localparam int unsigned PW = ptr_w(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(depth - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_digital.sv
// First-word-fall-through valid/ready FIFO buffering emulator samples.
// Optional sticky ovf/udf flags are built when FIFO_DIGITAL_FLAGS_EN is defined.
module fifo_digital
    import fifo_digital_pkg::*;
#(
    parameter int unsigned      width = 1,
    parameter int unsigned      depth = 4,
    parameter logic [width-1:0] init  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic [width-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [width-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [clog2_occ(depth)-1:0]  count
`ifdef FIFO_DIGITAL_FLAGS_EN
    ,
    output logic                         ovf,
    output logic                         udf
`endif
);

    localparam int unsigned CW = clog2_occ(depth);
    localparam int unsigned PW = ptr_w(depth);

    logic [width-1:0] mem_q [depth];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    op_e              op;

    assign in_ready  = (count_q != CW'(depth));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign op        = op_e'({push, pop});
    assign out_data  = out_valid ? mem_q[rd_ptr] : init;
    assign count     = count_q;

    fifo_digital_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fifo_digital_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is intentionally not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            case (op)
                OP_PUSH: count_d = count_q + CW'(1);
                OP_POP:  count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef FIFO_DIGITAL_FLAGS_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // Sticky error flags: refused offers and requests against an empty FIFO.
    always_comb begin
        ovf_d = ovf_q | (in_valid & ~in_ready);
        udf_d = udf_q | (out_ready & ~out_valid);
        if (clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_digital.sv
// Self-checking bench for fifo_digital (width=8, depth=4, init=0) against a queue model.
module tb_fifo_digital;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
`ifdef FIFO_DIGITAL_FLAGS_EN
    logic       ovf;
    logic       udf;
    bit         ovf_m;
    bit         udf_m;
`endif

    logic [7:0] q[$];
    int         n_cmp;
    int         n_err;

    fifo_digital #(.width(8), .depth(DEPTH), .init(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef FIFO_DIGITAL_FLAGS_EN
        ,
        .ovf       (ovf),
        .udf       (udf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 8'h00;
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
`ifdef FIFO_DIGITAL_FLAGS_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_m));
        chk({tag, "_udf"}, 32'(udf), 32'(udf_m));
`endif
    endtask

    // One clock: decide acceptance from the model, let the edge pass, update model, check.
    task automatic step(input string tag);
        bit psh;
        bit pp;
        bit full_pre;
        bit empty_pre;
        full_pre  = (q.size() == DEPTH);
        empty_pre = (q.size() == 0);
        psh = in_valid && !full_pre;
        pp  = out_ready && !empty_pre;
        @(posedge clk);
        if (clr) begin
            q.delete();
`ifdef FIFO_DIGITAL_FLAGS_EN
            ovf_m = 1'b0;
            udf_m = 1'b0;
`endif
        end else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(in_data);
`ifdef FIFO_DIGITAL_FLAGS_EN
            if (in_valid && full_pre) ovf_m = 1'b1;
            if (out_ready && empty_pre) udf_m = 1'b1;
`endif
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr       = c;
    endtask

    task automatic model_reset();
        q.delete();
`ifdef FIFO_DIGITAL_FLAGS_EN
        ovf_m = 1'b0;
        udf_m = 1'b0;
`endif
    endtask

    initial begin
        logic [7:0] pushes [4];
        n_cmp = 0;
        n_err = 0;
        pushes[0] = 8'h11;
        pushes[1] = 8'h22;
        pushes[2] = 8'h33;
        pushes[3] = 8'h44;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();

        // Reset state
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: fill with out_ready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pushes[i], 1'b0, 1'b0);
            step("t1_fill");
        end
        chk("t1_count_full", 32'(count), 32'd4);
        chk("t1_head", 32'(out_data), 32'h11);

        // 2: full, offer 0x55 while popping one
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        step("t2_full_pop");
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_head", 32'(out_data), 32'h22);

        // 3: drain to empty, then single push of 0xA5
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("t3_drain");
        chk("t3_empty_data", 32'(out_data), 32'h00);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step("t3_push");
        chk("t3_fwft_data", 32'(out_data), 32'hA5);
        chk("t3_fwft_valid", 32'(out_valid), 32'd1);

        // 4: build count=2, then sustained push&pop across the wrap
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        step("t4_prime");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0);
            step("t4_stream");
        end
        chk("t4_count_held", 32'(count), 32'd2);

        // 5: clr together with push 0x77 at count=3
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        step("t5_prime");
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        step("t5_clr");
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step("t5_after");
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        step("t5_repush");
        chk("t5_no_77", 32'(out_data), 32'h3C);

        // 6: async reset mid-burst, asserted between edges
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step("t6_burst");
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(negedge clk);
        check_all("t6_in_rst");
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step("t6_released");

`ifdef FIFO_DIGITAL_FLAGS_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step("t6_overfill");
        end
        chk("t6_ovf_set", 32'(ovf), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step("t6_ovf_sticky");
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step("t6_ovf_clr");
        chk("t6_ovf_cleared", 32'(ovf), 32'd0);
`endif

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
